text_cell_renderer: RTL and testbench

- Pipelined text-mode pixel generator for the VGA path.
- Takes pixel coordinates and syncs from the VGA timing block.
- Fetches the character and attribute word for the current cell from the text RAM, then fetches the glyph row from the glyph ROM, and emits a 4-bit colour index with syncs delayed to match.
- Generalises the fixed 8x8 combinational glyph lookup to parametrised glyph size, integer pixel scaling, per-cell colours and a fixed pipeline latency.

---
 rtl/text_cell_renderer.sv | 218 +++++++++++++++++++++
 tb/tb_text_cell_renderer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_cell_renderer.sv
// Text-mode pixel generator: coordinates -> text RAM -> glyph ROM -> colour index.
// Four register stages (S1..S4) with syncs and valid delayed to match.
// Optional blinking cursor is built when TEXT_CURSOR_EN is defined.
// Both memories register their address on this side: text_addr and glyph_char/glyph_row
// are the read-address registers, and the returned data is consumed on the next edge.
module text_cell_renderer #(
    parameter int unsigned GLYPH_W      = 8,
    parameter int unsigned GLYPH_H      = 8,
    parameter int unsigned SCALE        = 1,
    parameter int unsigned COLS         = 80,
    parameter int unsigned ROWS         = 60,
    parameter int unsigned COORD_W      = 10,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [COORD_W-1:0]            in_x,
    input  logic [COORD_W-1:0]            in_y,
    input  logic                          in_hsync,
    input  logic                          in_vsync,
    input  logic                          in_frame_start,
`ifdef TEXT_CURSOR_EN
    input  logic [$clog2(COLS)-1:0]       cursor_col,
    input  logic [$clog2(ROWS)-1:0]       cursor_row,
    input  logic                          cursor_on,
`endif
    output logic [$clog2(COLS*ROWS)-1:0]  text_addr,
    input  logic [15:0]                   text_data,
    output logic [7:0]                    glyph_char,
    output logic [$clog2(GLYPH_H)-1:0]    glyph_row,
    input  logic [GLYPH_W-1:0]            glyph_bits,
    output logic                          out_valid,
    output logic [3:0]                    out_color,
    output logic                          out_hsync,
    output logic                          out_vsync
);

    localparam int unsigned AW  = $clog2(COLS * ROWS);
    localparam int unsigned GXW = $clog2(GLYPH_W);
    localparam int unsigned GYW = $clog2(GLYPH_H);
    localparam int unsigned SSH = $clog2(SCALE);
    localparam int unsigned XSH = $clog2(GLYPH_W * SCALE);
    localparam int unsigned YSH = $clog2(GLYPH_H * SCALE);

    // Stage-1 combinational decode of the incoming coordinates
    logic [COORD_W-1:0] xs_c, ys_c, col_c, row_c;
    logic [GXW-1:0]     gx_c;
    logic [GYW-1:0]     gy_c;
    logic               txt_c;
    logic               cur_c;

    assign xs_c  = in_x >> SSH;
    assign ys_c  = in_y >> SSH;
    assign col_c = in_x >> XSH;
    assign row_c = in_y >> YSH;
    assign gx_c  = xs_c[GXW-1:0];
    assign gy_c  = ys_c[GYW-1:0];
    assign txt_c = (32'(col_c) < COLS) && (32'(row_c) < ROWS);

`ifdef TEXT_CURSOR_EN
    localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] frame_cnt;
    logic          blink_phase;

    // Frame counter: wraps after BLINK_FRAMES frame-start pulses and flips the blink phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (in_frame_start) begin
            if (32'(frame_cnt) == BLINK_FRAMES - 1) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + CW'(1);
            end
        end
    end

    // Cursor underline: bottom glyph row of the selected cell, visible phase only
    assign cur_c = cursor_on && blink_phase
                && (col_c == COORD_W'(cursor_col))
                && (row_c == COORD_W'(cursor_row))
                && (gy_c == GYW'(GLYPH_H - 1));
`else
    localparam int unsigned unused_blink_frames = BLINK_FRAMES;
    logic unused_frame_start;
    assign unused_frame_start = in_frame_start;
    assign cur_c = 1'b0;
`endif

    // S1 registers: coordinates and sideband
    logic               v1, hs1, vs1, txt1, cur1;
    logic [COORD_W-1:0] col1, row1;
    logic [GXW-1:0]     gx1;
    logic [GYW-1:0]     gy1;

    // Register the decoded coordinates of the incoming pixel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1   <= 1'b0;
            hs1  <= 1'b0;
            vs1  <= 1'b0;
            txt1 <= 1'b0;
            cur1 <= 1'b0;
            col1 <= '0;
            row1 <= '0;
            gx1  <= '0;
            gy1  <= '0;
        end else begin
            v1   <= in_valid;
            hs1  <= in_hsync;
            vs1  <= in_vsync;
            txt1 <= txt_c;
            cur1 <= cur_c;
            col1 <= col_c;
            row1 <= row_c;
            gx1  <= gx_c;
            gy1  <= gy_c;
        end
    end

    // S2 registers: text RAM address plus sideband
    logic           v2, hs2, vs2, txt2, cur2;
    logic [GXW-1:0] gx2;
    logic [GYW-1:0] gy2;
    logic [AW-1:0]  addr_c;

    assign addr_c = AW'(32'(row1) * COLS + 32'(col1));

    // Issue the text RAM read; border pixels leave the address untouched
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            text_addr <= '0;
            v2        <= 1'b0;
            hs2       <= 1'b0;
            vs2       <= 1'b0;
            txt2      <= 1'b0;
            cur2      <= 1'b0;
            gx2       <= '0;
            gy2       <= '0;
        end else begin
            if (txt1) begin
                text_addr <= addr_c;
            end
            v2   <= v1;
            hs2  <= hs1;
            vs2  <= vs1;
            txt2 <= txt1;
            cur2 <= cur1;
            gx2  <= gx1;
            gy2  <= gy1;
        end
    end

    // S3 registers: glyph ROM address and cell colours
    logic           v3, hs3, vs3, txt3, cur3;
    logic [GXW-1:0] gx3;
    logic [3:0]     fg3, bg3;

    // Capture the text word and issue the glyph ROM read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glyph_char <= '0;
            glyph_row  <= '0;
            fg3        <= '0;
            bg3        <= '0;
            v3         <= 1'b0;
            hs3        <= 1'b0;
            vs3        <= 1'b0;
            txt3       <= 1'b0;
            cur3       <= 1'b0;
            gx3        <= '0;
        end else begin
            glyph_char <= text_data[7:0];
            glyph_row  <= gy2;
            fg3        <= text_data[11:8];
            bg3        <= text_data[15:12];
            v3         <= v2;
            hs3        <= hs2;
            vs3        <= vs2;
            txt3       <= txt2;
            cur3       <= cur2;
            gx3        <= gx2;
        end
    end

    // Colour select: blanked outside the visible text area, cursor forces foreground
    logic [3:0] color_c;
    always_comb begin
        color_c = 4'h0;
        if (v3 && txt3) begin
            if (cur3 || glyph_bits[gx3]) begin
                color_c = fg3;
            end else begin
                color_c = bg3;
            end
        end
    end

    // S4 output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_color <= 4'h0;
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
        end else begin
            out_valid <= v3;
            out_color <= color_c;
            out_hsync <= hs3;
            out_vsync <= vs3;
        end
    end

endmodule

// File: tb/tb_text_cell_renderer.sv
// Directed bench for text_cell_renderer: default 8x8 instance plus a 16x16, SCALE=2 instance.
// Memories are modelled as arrays addressed by the DUT's registered read addresses.
module tb_text_cell_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_hsync, in_vsync, in_frame_start;
    logic [9:0]  in_x, in_y;
`ifdef TEXT_CURSOR_EN
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        cursor_on;
`endif

    // Default instance
    logic [12:0] text_addr;
    logic [15:0] text_data;
    logic [7:0]  glyph_char;
    logic [2:0]  glyph_row;
    logic [7:0]  glyph_bits;
    logic        out_valid, out_hsync, out_vsync;
    logic [3:0]  out_color;

    // 16x16 glyph, SCALE=2 instance
    logic [12:0] b_text_addr;
    logic [15:0] b_text_data;
    logic [7:0]  b_glyph_char;
    logic [3:0]  b_glyph_row;
    logic [15:0] b_glyph_bits;
    logic        b_out_valid, b_out_hsync, b_out_vsync;
    logic [3:0]  b_out_color;

    logic [15:0] tram [0:4799];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign text_data    = (text_addr < 13'd4800) ? tram[text_addr] : 16'h0000;
    assign b_text_data  = (b_text_addr < 13'd4800) ? tram[b_text_addr] : 16'h0000;
    assign glyph_bits   = (glyph_char == 8'h41 && glyph_row == 3'd0) ? 8'b0001_1100 : 8'h00;
    assign b_glyph_bits = (b_glyph_char == 8'h42 && b_glyph_row == 4'd3) ? 16'h0002 : 16'h0000;

    text_cell_renderer #(.BLINK_FRAMES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_x           (in_x),
        .in_y           (in_y),
        .in_hsync       (in_hsync),
        .in_vsync       (in_vsync),
        .in_frame_start (in_frame_start),
`ifdef TEXT_CURSOR_EN
        .cursor_col     (cursor_col),
        .cursor_row     (cursor_row),
        .cursor_on      (cursor_on),
`endif
        .text_addr      (text_addr),
        .text_data      (text_data),
        .glyph_char     (glyph_char),
        .glyph_row      (glyph_row),
        .glyph_bits     (glyph_bits),
        .out_valid      (out_valid),
        .out_color      (out_color),
        .out_hsync      (out_hsync),
        .out_vsync      (out_vsync)
    );

    text_cell_renderer #(.GLYPH_W(16), .GLYPH_H(16), .SCALE(2), .BLINK_FRAMES(2)) dut_big (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_x           (in_x),
        .in_y           (in_y),
        .in_hsync       (in_hsync),
        .in_vsync       (in_vsync),
        .in_frame_start (in_frame_start),
`ifdef TEXT_CURSOR_EN
        .cursor_col     (cursor_col),
        .cursor_row     (cursor_row),
        .cursor_on      (cursor_on),
`endif
        .text_addr      (b_text_addr),
        .text_data      (b_text_data),
        .glyph_char     (b_glyph_char),
        .glyph_row      (b_glyph_row),
        .glyph_bits     (b_glyph_bits),
        .out_valid      (b_out_valid),
        .out_color      (b_out_color),
        .out_hsync      (b_out_hsync),
        .out_vsync      (b_out_vsync)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int x, input int y);
        in_valid = v;
        in_x     = 10'(x);
        in_y     = 10'(y);
    endtask

    // Idle pixel lies in the border so it never moves text_addr
    task automatic idle();
        drive(1'b0, 1023, 1023);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".text_addr"}, 32'(text_addr), 0);
        chk({tag, ".glyph_char"}, 32'(glyph_char), 0);
        chk({tag, ".glyph_row"}, 32'(glyph_row), 0);
        chk({tag, ".out_valid"}, 32'(out_valid), 0);
        chk({tag, ".out_color"}, 32'(out_color), 0);
        chk({tag, ".out_hsync"}, 32'(out_hsync), 0);
        chk({tag, ".out_vsync"}, 32'(out_vsync), 0);
    endtask

    logic [3:0] scan_exp [0:7];

    initial begin
        for (int i = 0; i < 4800; i++) tram[i] = 16'h0000;
        tram[0]   = 16'h5A41;  // 'A', fg 0xA, bg 0x5
        tram[80]  = 16'h5A41;  // where an unguarded col=80 address would land
        tram[161] = 16'h3C42;  // 'B', fg 0xC, bg 0x3 (big instance)
        // glyph 8'b00011100 with bit 0 leftmost: x=0,1 bg; x=2..4 fg; x=5..7 bg
        scan_exp = '{4'h5, 4'h5, 4'hA, 4'hA, 4'hA, 4'h5, 4'h5, 4'h5};
        in_hsync       = 1'b0;
        in_vsync       = 1'b0;
        in_frame_start = 1'b0;
`ifdef TEXT_CURSOR_EN
        cursor_col = '0;
        cursor_row = '0;
        cursor_on  = 1'b1;
`endif

        // Reset held with random inputs: every output stays 0
        reset = 1'b0;
        drive(1'b1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_all_zero("rst_hold");
            drive(1'($urandom), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            in_hsync = 1'($urandom);
            in_vsync = 1'($urandom);
        end
        @(negedge clk);
        reset    = 1'b1;
        in_hsync = 1'b0;
        in_vsync = 1'b0;
        idle();
        repeat (3) @(negedge clk);

        // First valid pixel: cell (2,1) -> address 82; out_valid rises 4 cycles later
        drive(1'b1, 16, 8);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            if (j == 2) chk("addr_82", 32'(text_addr), 82);
            if (j < 4) chk("first_valid_low", 32'(out_valid), 0);
            else chk("first_valid_rise", 32'(out_valid), 1);
            idle();
        end

        // Right border x=640: valid passes, colour blanked, address held
        @(negedge clk);
        drive(1'b1, 640, 0);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            if (j == 2) chk("addr_hold_border", 32'(text_addr), 82);
            if (j == 4) begin
                chk("border_x_valid", 32'(out_valid), 1);
                chk("border_x_color", 32'(out_color), 0);
            end
            idle();
        end

        // Bottom border y=480
        @(negedge clk);
        drive(1'b1, 0, 480);
        repeat (4) begin
            @(negedge clk);
            idle();
        end
        chk("border_y_valid", 32'(out_valid), 1);
        chk("border_y_color", 32'(out_color), 0);

        // Invalid pixel over a foreground texel is forced to colour 0
        @(negedge clk);
        drive(1'b0, 2, 0);
        repeat (4) begin
            @(negedge clk);
            idle();
        end
        chk("invalid_valid", 32'(out_valid), 0);
        chk("invalid_color", 32'(out_color), 0);

        // Back-to-back scan of cell 0, row 0
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2) chk("scan_addr", 32'(text_addr), 0);
            if (i == 3) begin
                chk("scan_glyph_char", 32'(glyph_char), 32'h41);
                chk("scan_glyph_row", 32'(glyph_row), 0);
            end
            if (i >= 4) begin
                chk("scan_valid", 32'(out_valid), 1);
                chk("scan_color", 32'(out_color), 32'(scan_exp[i-4]));
            end
            if (i < 8) drive(1'b1, i, 0);
            else idle();
        end

        // 16x16 glyphs, SCALE=2: x=35,y=70 -> col 1, row 2, gx 1, gy 3
        @(negedge clk);
        drive(1'b1, 35, 70);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            if (j == 2) chk("big_addr", 32'(b_text_addr), 161);
            if (j == 3) begin
                chk("big_glyph_row", 32'(b_glyph_row), 3);
                chk("big_glyph_char", 32'(b_glyph_char), 32'h42);
            end
            if (j == 4) chk("big_color_gx1", 32'(b_out_color), 32'hC);
            idle();
        end

        // 96-cycle hsync pulse shifted by exactly 4 cycles
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            chk("hsync_delay", 32'(out_hsync), 32'((i >= 4) && (i < 100)));
            in_hsync = (i < 96);
        end
        // Same for vsync
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            chk("vsync_delay", 32'(out_vsync), 32'((i >= 4) && (i < 100)));
            in_vsync = (i < 96);
        end

        // Mid-stream reset flushes the pipeline
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b1, i, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_all_zero("rst_mid");
        end
        reset = 1'b1;
        idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("flush_valid", 32'(out_valid), 0);
            chk("flush_color", 32'(out_color), 0);
        end

`ifdef TEXT_CURSOR_EN
        // Cursor at (0,0), blank glyph, fg 0xF / bg 0x3. Frame 0 is the one already running
        // after reset; frames 1..4 each open with a frame-start pulse.
        tram[0] = 16'h3F00;
        for (int f = 0; f < 5; f++) begin
            if (f > 0) begin
                @(negedge clk);
                in_frame_start = 1'b1;
                idle();
                @(negedge clk);
                in_frame_start = 1'b0;
            end
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (i >= 4) chk("cursor_color", 32'(out_color), (f == 2 || f == 3) ? 32'hF : 32'h3);
                if (i < 8) drive(1'b1, i, 7);
                else idle();
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
